// File: rtl/racl_error_logger_pkg.sv
// Shared RACL types: role vector, channel limits and the packed error-log record
// consumed by the safety/BIST status CSR block.
package racl_error_logger_pkg;

    localparam int RACL_ROLE_W     = 4;
    localparam int RACL_NUM_CH_MAX = 16;
    localparam int RACL_ADDR_W     = 32;

    typedef logic [RACL_ROLE_W-1:0] racl_role_t;

    typedef struct packed {
        logic                   valid;
        logic                   overflow;
        logic                   write;
        logic [3:0]             ch;
        racl_role_t             role;
        logic [RACL_ADDR_W-1:0] addr;
    } racl_error_log_t;

    // Channel-index width, never narrower than one bit.
    function automatic int racl_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/racl_error_logger_if.sv
// Bundle between the per-port RACL checkers / CSR clear and the error logger.
interface racl_error_logger_if
    import racl_error_logger_pkg::*;
#(
    parameter int NumCh = 4,
    parameter int AddrW = 32,
    parameter int RoleW = 4,
    parameter int CntW  = 8
);
    localparam int IdxW = racl_idx_w(NumCh);

    logic [NumCh-1:0]       err_valid_i;
    logic [NumCh*AddrW-1:0] err_addr_i;
    logic [NumCh-1:0]       err_write_i;
    logic [NumCh*RoleW-1:0] err_role_i;
    logic                   clr_i;

    logic                   log_valid_o;
    logic                   log_overflow_o;
    logic [AddrW-1:0]       log_addr_o;
    logic                   log_write_o;
    logic [RoleW-1:0]       log_role_o;
    logic [IdxW-1:0]        log_ch_o;
    logic [CntW-1:0]        err_cnt_o;
    logic                   irq_o;

    modport master (
        output err_valid_i, err_addr_i, err_write_i, err_role_i, clr_i,
        input  log_valid_o, log_overflow_o, log_addr_o, log_write_o,
               log_role_o, log_ch_o, err_cnt_o, irq_o
    );

    modport slave (
        input  err_valid_i, err_addr_i, err_write_i, err_role_i, clr_i,
        output log_valid_o, log_overflow_o, log_addr_o, log_write_o,
               log_role_o, log_ch_o, err_cnt_o, irq_o
    );

endinterface

// File: rtl/racl_error_logger_prio_popcnt.sv
// Lowest-index priority encoder plus population count over the denial strobes.
module racl_prio_popcnt
    import racl_error_logger_pkg::*;
#(
    parameter  int NumCh = 4,
    localparam int IdxW  = racl_idx_w(NumCh),
    localparam int PcW   = $clog2(NumCh + 1)
) (
    input  logic [NumCh-1:0] vec,
    output logic [IdxW-1:0]  idx,
    output logic [PcW-1:0]   cnt,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx = '0;
        cnt = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int k = NumCh - 1; k >= 0; k--) begin
            if (vec[k]) idx = IdxW'(k);
        end
        for (int k = 0; k < NumCh; k++) begin
            cnt = cnt + PcW'(vec[k]);
        end
        any   = |vec;
        multi = (cnt > PcW'(1));
    end

endmodule

// File: rtl/racl_error_logger.sv
// RACL violation logger: holds the first denied access, flags later ones as
// overflow, counts all denials and raises a level irq until cleared.
module racl_error_logger
    import racl_error_logger_pkg::*;
#(
    parameter int NumCh = 4,
    parameter int AddrW = 32,
    parameter int RoleW = 4,
    parameter int CntW  = 8
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    racl_error_logger_if.slave  bus
);

    localparam int IdxW = racl_idx_w(NumCh);
    localparam int PcW  = $clog2(NumCh + 1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HELD  = 1'b1;

    function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a,
                                                input logic [PcW-1:0]  b);
        logic [CntW+PcW-1:0] sum;
        sum = {{PcW{1'b0}}, a} + {{CntW{1'b0}}, b};
        if (|sum[CntW+PcW-1:CntW]) return '1;
        return sum[CntW-1:0];
    endfunction

    logic [IdxW-1:0] sel_idx;
    logic [PcW-1:0]  err_pc;
    logic            err_any;
    logic            err_multi;

    racl_prio_popcnt #(.NumCh(NumCh)) u_prio (
        .vec   (bus.err_valid_i),
        .idx   (sel_idx),
        .cnt   (err_pc),
        .any   (err_any),
        .multi (err_multi)
    );

    logic [AddrW-1:0] sel_addr;
    logic             sel_write;
    logic [RoleW-1:0] sel_role;

    always_comb begin
        sel_addr  = bus.err_addr_i[sel_idx*AddrW +: AddrW];
        sel_write = bus.err_write_i[sel_idx];
        sel_role  = bus.err_role_i[sel_idx*RoleW +: RoleW];
    end

    logic [0:0]       state_p1;
    logic             ovf_p1;
    logic [AddrW-1:0] addr_p1;
    logic             write_p1;
    logic [RoleW-1:0] role_p1;
    logic [IdxW-1:0]  ch_p1;
    logic [CntW-1:0]  cnt_p1;

    // Capture stage: a clear behaves like EMPTY for same-cycle denials.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_p1 <= EMPTY;
            ovf_p1   <= 1'b0;
            addr_p1  <= '0;
            write_p1 <= 1'b0;
            role_p1  <= '0;
            ch_p1    <= '0;
            cnt_p1   <= '0;
        end else begin
            cnt_p1 <= sat_add(bus.clr_i ? '0 : cnt_p1, err_pc);
            if (bus.clr_i || state_p1 == EMPTY) begin
                state_p1 <= err_any ? HELD : EMPTY;
                ovf_p1   <= err_multi;
                addr_p1  <= err_any ? sel_addr  : '0;
                write_p1 <= err_any ? sel_write : 1'b0;
                role_p1  <= err_any ? sel_role  : '0;
                ch_p1    <= err_any ? sel_idx   : '0;
            end else if (err_any) begin
                ovf_p1 <= 1'b1;
            end
        end
    end

    generate
        if (AddrW == RACL_ADDR_W && RoleW == RACL_ROLE_W) begin : g_rec
            racl_error_log_t log_rec;

            always_comb begin
                log_rec          = '0;
                log_rec.valid    = (state_p1 == HELD);
                log_rec.overflow = ovf_p1;
                log_rec.write    = write_p1;
                log_rec.ch       = 4'(ch_p1);
                log_rec.role     = racl_role_t'(role_p1);
                log_rec.addr     = RACL_ADDR_W'(addr_p1);
            end

            assign bus.log_valid_o    = log_rec.valid;
            assign bus.log_overflow_o = log_rec.overflow;
            assign bus.log_write_o    = log_rec.write;
            assign bus.log_ch_o       = IdxW'(log_rec.ch);
            assign bus.log_role_o     = RoleW'(log_rec.role);
            assign bus.log_addr_o     = AddrW'(log_rec.addr);
            assign bus.irq_o          = log_rec.valid;
        end else begin : g_raw
            assign bus.log_valid_o    = (state_p1 == HELD);
            assign bus.log_overflow_o = ovf_p1;
            assign bus.log_write_o    = write_p1;
            assign bus.log_ch_o       = ch_p1;
            assign bus.log_role_o     = role_p1;
            assign bus.log_addr_o     = addr_p1;
            assign bus.irq_o          = (state_p1 == HELD);
        end
    endgenerate

    assign bus.err_cnt_o = cnt_p1;

endmodule

// File: tb/tb_racl_error_logger.sv
// Directed bench for racl_error_logger: vector table plus saturation and
// reset-override sequences, with a 4-bit counter so saturation is reachable.
module tb_racl_error_logger;

    localparam int NumCh = 4;
    localparam int AddrW = 32;
    localparam int RoleW = 4;
    localparam int CntW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    racl_error_logger_if #(.NumCh(NumCh), .AddrW(AddrW), .RoleW(RoleW), .CntW(CntW)) bus ();

    racl_error_logger #(.NumCh(NumCh), .AddrW(AddrW), .RoleW(RoleW), .CntW(CntW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        clr;
        logic [3:0]  vld;
        logic [3:0]  wr;
        logic [31:0] base;
        logic        e_valid;
        logic        e_ovf;
        logic [1:0]  e_ch;
        logic [31:0] e_addr;
        logic        e_write;
        logic [3:0]  e_role;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl[13];

    // Channel k sees address base + k*0x20 and role k+1.
    task automatic drive(input logic clr, input logic [3:0] vld,
                         input logic [3:0] wr, input logic [31:0] base);
        bus.clr_i       = clr;
        bus.err_valid_i = vld;
        bus.err_write_i = wr;
        for (int k = 0; k < NumCh; k++) begin
            bus.err_addr_i[k*AddrW +: AddrW] = base + 32'(k) * 32'h20;
            bus.err_role_i[k*RoleW +: RoleW] = 4'(k + 1);
        end
    endtask

    task automatic check(input string name, input logic valid, input logic ovf,
                         input logic [1:0] ch, input logic [31:0] addr,
                         input logic write, input logic [3:0] role,
                         input logic [3:0] cnt);
        logic [45:0] got;
        logic [45:0] exp;
        got = {bus.log_valid_o, bus.log_overflow_o, bus.log_ch_o, bus.log_addr_o,
               bus.log_write_o, bus.log_role_o, bus.err_cnt_o, bus.irq_o};
        exp = {valid, ovf, ch, addr, write, role, cnt, valid};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b ovf=%b ch=%0d addr=%h w=%b role=%h cnt=%0d irq=%b, want v=%b ovf=%b ch=%0d addr=%h w=%b role=%h cnt=%0d irq=%b",
                     name, got[45], got[44], got[43:42], got[41:10], got[9], got[8:5],
                     got[4:1], got[0], valid, ovf, ch, addr, write, role, cnt, valid);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            clr  vld      wr       base          v  ovf ch  addr          w  role  cnt
        tbl[0]  = '{1'b0, 4'b0100, 4'b0100, 32'h1000_0000, 1, 0, 2, 32'h1000_0040, 1, 4'h3, 4'd1};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 32'h5555_0000, 1, 0, 2, 32'h1000_0040, 1, 4'h3, 4'd1};
        tbl[2]  = '{1'b0, 4'b1000, 4'b0000, 32'h6666_0000, 1, 1, 2, 32'h1000_0040, 1, 4'h3, 4'd2};
        tbl[3]  = '{1'b0, 4'b1000, 4'b0000, 32'h6666_0000, 1, 1, 2, 32'h1000_0040, 1, 4'h3, 4'd3};
        tbl[4]  = '{1'b0, 4'b1000, 4'b0000, 32'h6666_0000, 1, 1, 2, 32'h1000_0040, 1, 4'h3, 4'd4};
        tbl[5]  = '{1'b1, 4'b0001, 4'b0001, 32'hDEAD_0000, 1, 0, 0, 32'hDEAD_0000, 1, 4'h1, 4'd1};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 0, 4'h0, 4'd0};
        tbl[7]  = '{1'b0, 4'b1010, 4'b0010, 32'h2000_0000, 1, 1, 1, 32'h2000_0020, 1, 4'h2, 4'd2};
        tbl[8]  = '{1'b1, 4'b0110, 4'b0000, 32'h3000_0000, 1, 1, 1, 32'h3000_0020, 0, 4'h2, 4'd2};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 0, 0, 0, 32'h0000_0000, 0, 4'h0, 4'd0};
        tbl[10] = '{1'b0, 4'b0000, 4'b1111, 32'h7777_0000, 0, 0, 0, 32'h0000_0000, 0, 4'h0, 4'd0};
        tbl[11] = '{1'b0, 4'b1000, 4'b1000, 32'h4000_0000, 1, 0, 3, 32'h4000_0060, 1, 4'h4, 4'd1};
        tbl[12] = '{1'b0, 4'b0011, 4'b0000, 32'h8888_0000, 1, 1, 3, 32'h4000_0060, 1, 4'h4, 4'd3};

        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 32'h0, 0, 4'h0, 4'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].clr, tbl[i].vld, tbl[i].wr, tbl[i].base);
            step();
            check($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ovf, tbl[i].e_ch,
                  tbl[i].e_addr, tbl[i].e_write, tbl[i].e_role, tbl[i].e_cnt);
        end

        // Counter saturation: clear, then all four channels for five cycles.
        drive(1'b1, 4'b0000, 4'b0000, 32'h0);
        step();
        check("sat_clr", 0, 0, 0, 32'h0, 0, 4'h0, 4'd0);
        for (int c = 0; c < 5; c++) begin
            logic [3:0] want;
            want = (c < 3) ? 4'(4 * (c + 1)) : 4'd15;
            drive(1'b0, 4'b1111, 4'b0101, 32'h9000_0000);
            step();
            check($sformatf("sat%0d", c), 1, 1, 0, 32'h9000_0000, 1, 4'h1, want);
        end

        // Reset overrides clear and errors while held with overflow set.
        rst_n = 1'b0;
        drive(1'b1, 4'b1111, 4'b1111, 32'hA000_0000);
        step();
        check("rst_override", 0, 0, 0, 32'h0, 0, 4'h0, 4'd0);

        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 32'h0);
        step();
        check("rst_idle", 0, 0, 0, 32'h0, 0, 4'h0, 4'd0);

        // A single denial right after reset must be captured, proving EMPTY.
        drive(1'b0, 4'b0010, 4'b0000, 32'hB000_0000);
        step();
        check("rst_empty", 1, 0, 1, 32'hB000_0020, 0, 4'h2, 4'd1);

        drive(1'b0, 4'b0000, 4'b0000, 32'h0);
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
